// File: rtl/tc_call_stack_pkg.sv
// Shared types and helpers for the call/return address stack.
package tc_call_stack_pkg;

   // One operation is executed per cycle; the decode below picks it.
   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_JUMP = 2'd1,
      OP_CALL = 2'd2,
      OP_RET  = 2'd3
   } op_e;

   // Fixed priority: ret beats call beats jump. Losers have no side effects.
   function automatic op_e decode_op(input logic ret, input logic call, input logic jump);
      if (ret)       return OP_RET;
      else if (call) return OP_CALL;
      else if (jump) return OP_JUMP;
      return OP_NONE;
   endfunction

endpackage

// File: rtl/tc_lifo.sv
// Register-array LIFO with a saturating depth counter. Push is ignored when
// full and pop is ignored when empty; the caller keeps them exclusive.
module tc_lifo #(
   parameter int BIT_WIDTH = 8,
   parameter int DEPTH     = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [BIT_WIDTH-1:0]         wr_data,
   output logic [BIT_WIDTH-1:0]         top,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         full,
   output logic                         empty
);

   localparam int DW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);

   logic [BIT_WIDTH-1:0] mem_q [DEPTH];
   logic [DW-1:0]        depth_q, depth_d;
   logic [AW-1:0]        wr_idx, rd_idx;

   assign empty  = (depth_q == '0);
   assign full   = (depth_q == DW'(DEPTH));
   assign depth  = depth_q;
   assign wr_idx = depth_q[AW-1:0];
   assign rd_idx = AW'(depth_q - DW'(1));
   // Entries at or above depth are stale; never expose them.
   assign top    = empty ? '0 : mem_q[rd_idx];

   // Next depth: saturates at 0 and DEPTH.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
      depth_d = depth_q;
      if (pop && !empty)
         depth_d = depth_q - DW'(1);
      else if (push && !full)
         depth_d = depth_q + DW'(1);
   end

   // Depth counter register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
      if (rst) depth_q <= '0;
      else     depth_q <= depth_d;
   end

   // Storage write; entries above depth are don't-care.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset on purpose; only depth is reset, which keeps it a plain register file.
      if (!rst && push && !pop && !full)
         mem_q[wr_idx] <= wr_data;
   end

endmodule

// File: rtl/tc_call_stack.sv
// Return-address stack feeding a program counter's synchronous-load path.
// Load strobe/value are combinational so the counter captures them at the
// same edge the stack updates.
module tc_call_stack
   import tc_call_stack_pkg::*;
#(
   parameter int BIT_WIDTH = 8,
   parameter int DEPTH     = 8,
   parameter int STEP      = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [BIT_WIDTH-1:0]         pc,
   input  logic                         call,
   input  logic                         ret,
   input  logic                         jump,
   input  logic [BIT_WIDTH-1:0]         target,
   output logic                         load,
   output logic [BIT_WIDTH-1:0]         load_value,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         empty,
   output logic                         full,
   output logic                         overflow,
   output logic                         underflow
);

   op_e                  op;
   logic                 push, pop;
   logic [BIT_WIDTH-1:0] ret_addr;
   logic [BIT_WIDTH-1:0] top;
   logic                 overflow_q, overflow_d;
   logic                 underflow_q, underflow_d;

   assign op       = decode_op(ret, call, jump);
   // Width-truncated add gives the required modulo-2^BIT_WIDTH wrap.
   assign ret_addr = pc + BIT_WIDTH'(STEP);

   tc_lifo #(
      .BIT_WIDTH (BIT_WIDTH),
      .DEPTH     (DEPTH)
   ) u_lifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data (ret_addr),
      .top     (top),
      .depth   (depth),
      .full    (full),
      .empty   (empty)
   );

   // Load mux, stack control and sticky-flag next state.
   always_comb begin
      load        = 1'b0;
      load_value  = '0;
      push        = 1'b0;
      pop         = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (!rst) begin
         unique case (op)
            OP_RET: begin
               if (empty) begin
                  underflow_d = 1'b1;
               end else begin
                  load       = 1'b1;
                  load_value = top;
                  pop        = 1'b1;
               end
            end
            OP_CALL: begin
               load       = 1'b1;
               load_value = target;
               if (full) overflow_d = 1'b1;
               else      push       = 1'b1;
            end
            OP_JUMP: begin
               load       = 1'b1;
               load_value = target;
            end
            default: ;
         endcase
      end
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule
